// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
//
// Game-flow controller for the three-screen display path. It decides which
// screen the display multiplexer shows (welcome / play / game over). It also
// keeps track of lives, level, pause and the win/lose outcome. It issues
// one-cycle start pulses that reinitialise the game objects.
//
// Ports:
//   clk              system clock
//   resetN           asynchronous active-low reset
//   startOfFrame     one-cycle pulse per video frame
//   startKey         debounced start key level, active high
//   pauseKey         debounced pause key level, active high
//   playerDied       one-cycle pulse, player was hit
//   levelCleared     one-cycle pulse, all bubbles destroyed
//   selector[1:0]    0 welcome, 1 play, 2 game over (never 3); this is the
//                    FSM state register itself, so it doubles as state debug
//   livesLeft[2:0]   remaining lives
//   level[3:0]       current level, 0-based
//   paused           play frozen
//   gameActive       selector==1 and !paused
//   win              last game ended by clearing the final level
//   newGamePulse     one cycle on entry to play
//   levelStartPulse  one cycle on entry to each level (including level 0
//                    and restarts after losing a life)
//
// Timing: every output except gameActive is a flop. An input event is
// visible after the next rising clk edge. gameActive is decoded from
// registered state and paused without adding latency.
// -----------------------------------------------------------------------------
module screen_sequencer #(
  parameter int LIVES              = 3,
  parameter int NUM_LEVELS         = 4,
  parameter int WELCOME_MIN_FRAMES = 30,
  parameter int GAMEOVER_FRAMES    = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       playerDied,
  input  logic       levelCleared,
  output logic [1:0] selector,
  output logic [2:0] livesLeft,
  output logic [3:0] level,
  output logic       paused,
  output logic       gameActive,
  output logic       win,
  output logic       newGamePulse,
  output logic       levelStartPulse
);

  // Encoding equals the selector code, so the state register drives the
  // display multiplexer directly.
  typedef enum logic [1:0] {
    ST_WELCOME  = 2'd0,
    ST_PLAY     = 2'd1,
    ST_GAMEOVER = 2'd2
  } state_t;

  localparam logic [2:0] LIVES_INIT  = 3'(LIVES);
  localparam logic [3:0] LAST_LEVEL  = 4'(NUM_LEVELS - 1);
  localparam logic [9:0] WELCOME_MIN = 10'(WELCOME_MIN_FRAMES);
  localparam logic [9:0] GO_HOLD     = 10'(GAMEOVER_FRAMES);
  localparam logic [9:0] FRAME_MAX   = 10'h3FF;

  state_t     state;
  state_t     state_n;
  logic [9:0] frame_cnt;
  logic [9:0] frame_cnt_n;
  logic       start_d;
  logic       pause_d;
  logic       start_rise;
  logic       pause_rise;

  logic [2:0] lives_n;
  logic [3:0] level_n;
  logic       paused_n;
  logic       win_n;
  logic       new_game_n;
  logic       level_start_n;

  // The history registers reset to 0. A key held through reset release
  // therefore reads as one rise on the first cycle.
  assign start_rise = startKey & ~start_d;
  assign pause_rise = pauseKey & ~pause_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n       = state;
    lives_n       = livesLeft;
    level_n       = level;
    paused_n      = 1'b0;
    win_n         = win;
    new_game_n    = 1'b0;
    level_start_n = 1'b0;

    case (state)
      ST_WELCOME: begin
        // Early presses are dropped, not remembered.
        if (start_rise && (frame_cnt >= WELCOME_MIN)) begin
          state_n       = ST_PLAY;
          lives_n       = LIVES_INIT;
          level_n       = 4'd0;
          win_n         = 1'b0;
          new_game_n    = 1'b1;
          level_start_n = 1'b1;
        end
      end

      ST_PLAY: begin
        paused_n = paused ^ pause_rise;
        // Game events are gated by the paused value from before this
        // cycle's toggle. A death takes priority over a clear that arrives
        // in the same cycle.
        if (!paused) begin
          if (playerDied) begin
            if (livesLeft == 3'd1) begin
              lives_n = 3'd0;
              win_n   = 1'b0;
              state_n = ST_GAMEOVER;
            end else begin
              lives_n       = livesLeft - 3'd1;
              level_start_n = 1'b1;
            end
          end else if (levelCleared) begin
            if (level == LAST_LEVEL) begin
              win_n   = 1'b1;
              state_n = ST_GAMEOVER;
            end else begin
              level_n       = level + 4'd1;
              level_start_n = 1'b1;
            end
          end
        end
        // The game-over screen is never shown frozen.
        if (state_n != ST_PLAY) begin
          paused_n = 1'b0;
        end
      end

      ST_GAMEOVER: begin
        if (frame_cnt >= GO_HOLD) begin
          state_n = ST_WELCOME;
        end
      end

      default: begin
        state_n = ST_WELCOME;
      end
    endcase
  end

  // Frame counter restarts on every screen change, so each screen measures
  // its own dwell time from 0.
  always_comb begin
    frame_cnt_n = frame_cnt;
    if (state_n != state) begin
      frame_cnt_n = 10'd0;
    end else if (startOfFrame && (frame_cnt != FRAME_MAX)) begin
      frame_cnt_n = frame_cnt + 10'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= ST_WELCOME;
      frame_cnt       <= 10'd0;
      start_d         <= 1'b0;
      pause_d         <= 1'b0;
      livesLeft       <= 3'd0;
      level           <= 4'd0;
      paused          <= 1'b0;
      win             <= 1'b0;
      newGamePulse    <= 1'b0;
      levelStartPulse <= 1'b0;
    end else begin
      state           <= state_n;
      frame_cnt       <= frame_cnt_n;
      start_d         <= startKey;
      pause_d         <= pauseKey;
      livesLeft       <= lives_n;
      level           <= level_n;
      paused          <= paused_n;
      win             <= win_n;
      newGamePulse    <= new_game_n;
      levelStartPulse <= level_start_n;
    end
  end

  assign selector   = state;
  assign gameActive = (state == ST_PLAY) && !paused;

endmodule

// File: tb/tb_screen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_screen_sequencer
//
// Self-checking bench for screen_sequencer. A behavioural game model follows
// the game rules each clock: which screen is shown, lives, level, pause and
// outcome, plus the frame dwell counter. The model is compared with every
// DUT output on every falling edge. The directed scenarios also check fixed
// values. They are followed by a long random-event run.
// -----------------------------------------------------------------------------
module tb_screen_sequencer;

  localparam int LIVES      = 3;
  localparam int NUM_LEVELS = 4;
  localparam int WMIN       = 30;
  localparam int GO_FRAMES  = 180;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk          = 1'b0;
  logic resetN       = 1'b0;
  logic startOfFrame = 1'b0;
  logic startKey     = 1'b0;
  logic pauseKey     = 1'b0;
  logic playerDied   = 1'b0;
  logic levelCleared = 1'b0;

  logic [1:0] selector;
  logic [2:0] livesLeft;
  logic [3:0] level;
  logic       paused;
  logic       gameActive;
  logic       win;
  logic       newGamePulse;
  logic       levelStartPulse;

  always #5 clk = ~clk;

  screen_sequencer #(
    .LIVES              (LIVES),
    .NUM_LEVELS         (NUM_LEVELS),
    .WELCOME_MIN_FRAMES (WMIN),
    .GAMEOVER_FRAMES    (GO_FRAMES)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .startKey        (startKey),
    .pauseKey        (pauseKey),
    .playerDied      (playerDied),
    .levelCleared    (levelCleared),
    .selector        (selector),
    .livesLeft       (livesLeft),
    .level           (level),
    .paused          (paused),
    .gameActive      (gameActive),
    .win             (win),
    .newGamePulse    (newGamePulse),
    .levelStartPulse (levelStartPulse)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the game rules, one step per clock
  // ---------------------------------------------------------------------------
  int m_screen;      // 0 welcome, 1 play, 2 game over
  int m_lives;
  int m_level;
  int m_paused;
  int m_win;
  int m_new_game;
  int m_level_start;
  int m_frames;
  int m_prev_start;
  int m_prev_pause;

  function automatic void model_reset();
    m_screen      = 0;
    m_lives       = 0;
    m_level       = 0;
    m_paused      = 0;
    m_win         = 0;
    m_new_game    = 0;
    m_level_start = 0;
    m_frames      = 0;
    m_prev_start  = 0;
    m_prev_pause  = 0;
  endfunction

  function automatic void model_step();
    int start_pressed;
    int pause_pressed;
    int was_paused;
    int old_screen;
    start_pressed = (startKey && !m_prev_start) ? 1 : 0;
    pause_pressed = (pauseKey && !m_prev_pause) ? 1 : 0;
    was_paused    = m_paused;
    old_screen    = m_screen;
    m_new_game    = 0;
    m_level_start = 0;

    if (m_screen == 0) begin
      if (start_pressed != 0 && m_frames >= WMIN) begin
        m_screen      = 1;
        m_lives       = LIVES;
        m_level       = 0;
        m_win         = 0;
        m_paused      = 0;
        m_new_game    = 1;
        m_level_start = 1;
      end
    end else if (m_screen == 1) begin
      if (was_paused == 0) begin
        if (playerDied) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_win    = 0;
            m_screen = 2;
          end else begin
            m_level_start = 1;
          end
        end else if (levelCleared) begin
          if (m_level == NUM_LEVELS - 1) begin
            m_win    = 1;
            m_screen = 2;
          end else begin
            m_level       = m_level + 1;
            m_level_start = 1;
          end
        end
      end
      m_paused = (pause_pressed != 0) ? 1 - was_paused : was_paused;
      if (m_screen != 1) m_paused = 0;
    end else begin
      m_paused = 0;
      if (m_frames >= GO_FRAMES) m_screen = 0;
    end

    if (m_screen != old_screen) m_frames = 0;
    else if (startOfFrame) m_frames = (m_frames + 1 > 1023) ? 1023 : m_frames + 1;

    m_prev_start = startKey ? 1 : 0;
    m_prev_pause = pauseKey ? 1 : 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".selector"},   32'(selector),        32'(m_screen));
    check({tag, ".not3"},       32'(selector == 2'd3), 32'd0);
    check({tag, ".livesLeft"},  32'(livesLeft),       32'(m_lives));
    check({tag, ".level"},      32'(level),           32'(m_level));
    check({tag, ".paused"},     32'(paused),          32'(m_paused));
    check({tag, ".gameActive"}, 32'(gameActive),      32'((m_screen == 1 && m_paused == 0) ? 1 : 0));
    check({tag, ".win"},        32'(win),             32'(m_win));
    check({tag, ".newGame"},    32'(newGamePulse),    32'(m_new_game));
    check({tag, ".levelStart"}, 32'(levelStartPulse), 32'(m_level_start));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change on the falling edge and outputs are sampled
  // on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    if (!resetN) model_reset();
    else model_step();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic idle(input int n, input logic sof);
    startOfFrame = sof;
    repeat (n) tick();
    startOfFrame = 1'b0;
  endtask

  task automatic start_game();
    idle(WMIN, 1'b1);
    startKey = 1'b1;
    tick();
    startKey = 1'b0;
    check("start.selector", 32'(selector), 32'd1);
    check("start.newGame",  32'(newGamePulse), 32'd1);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();

    // 1: start key held through reset release; early rise is discarded
    resetN   = 1'b0;
    startKey = 1'b1;
    repeat (3) tick();
    check("t1.reset_sel",   32'(selector), 32'd0);
    check("t1.reset_lives", 32'(livesLeft), 32'd0);
    resetN = 1'b1;
    tick();
    check("t1.early_sel", 32'(selector), 32'd0);
    check("t1.early_ng",  32'(newGamePulse), 32'd0);
    idle(WMIN, 1'b1);
    check("t1.held_sel", 32'(selector), 32'd0);
    startKey = 1'b0;
    tick();
    startKey = 1'b1;
    tick();
    check("t1.sel",   32'(selector), 32'd1);
    check("t1.lives", 32'(livesLeft), 32'd3);
    check("t1.level", 32'(level), 32'd0);
    check("t1.ng",    32'(newGamePulse), 32'd1);
    check("t1.ls",    32'(levelStartPulse), 32'd1);
    startKey = 1'b0;
    tick();
    check("t1.ng_one", 32'(newGamePulse), 32'd0);
    check("t1.ls_one", 32'(levelStartPulse), 32'd0);

    // 2: lose all lives, then automatic return to welcome
    for (int i = 0; i < 3; i++) begin
      playerDied = 1'b1;
      tick();
      playerDied = 1'b0;
      check("t2.lives", 32'(livesLeft), 32'(2 - i));
      if (i < 2) check("t2.ls", 32'(levelStartPulse), 32'd1);
      idle(99, 1'b0);
    end
    check("t2.sel_go", 32'(selector), 32'd2);
    check("t2.win",    32'(win), 32'd0);
    idle(GO_FRAMES, 1'b1);
    check("t2.go_hold", 32'(selector), 32'd2);
    tick();
    check("t2.sel_welcome", 32'(selector), 32'd0);

    // 3: clear every level and win
    start_game();
    for (int i = 0; i < NUM_LEVELS; i++) begin
      levelCleared = 1'b1;
      tick();
      levelCleared = 1'b0;
      if (i < NUM_LEVELS - 1) begin
        check("t3.level", 32'(level), 32'(i + 1));
        check("t3.ls",    32'(levelStartPulse), 32'd1);
      end else begin
        check("t3.sel_go",  32'(selector), 32'd2);
        check("t3.win",     32'(win), 32'd1);
        check("t3.level_h", 32'(level), 32'd3);
      end
      idle(5, 1'b0);
    end
    idle(GO_FRAMES + 1, 1'b1);
    check("t3.sel_welcome", 32'(selector), 32'd0);

    // 4: pause freezes events
    start_game();
    pauseKey = 1'b1;
    tick();
    pauseKey = 1'b0;
    check("t4.paused", 32'(paused), 32'd1);
    check("t4.active", 32'(gameActive), 32'd0);
    playerDied = 1'b1;
    tick();
    playerDied   = 1'b0;
    levelCleared = 1'b1;
    tick();
    levelCleared = 1'b0;
    check("t4.lives", 32'(livesLeft), 32'd3);
    check("t4.level", 32'(level), 32'd0);
    pauseKey = 1'b1;
    tick();
    pauseKey = 1'b0;
    check("t4.unpaused", 32'(paused), 32'd0);
    check("t4.active2",  32'(gameActive), 32'd1);

    // 5: simultaneous death and clear
    playerDied   = 1'b1;
    levelCleared = 1'b1;
    tick();
    playerDied   = 1'b0;
    levelCleared = 1'b0;
    check("t5.lives", 32'(livesLeft), 32'd2);
    check("t5.level", 32'(level), 32'd0);
    check("t5.ls",    32'(levelStartPulse), 32'd1);
    tick();
    check("t5.ls_one", 32'(levelStartPulse), 32'd0);

    // 6: asynchronous reset in the middle of play at level 2
    levelCleared = 1'b1;
    tick();
    levelCleared = 1'b0;
    tick();
    levelCleared = 1'b1;
    tick();
    levelCleared = 1'b0;
    check("t6.level2", 32'(level), 32'd2);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all("t6.async");
    check("t6.sel",   32'(selector), 32'd0);
    check("t6.level", 32'(level), 32'd0);
    repeat (2) tick();
    resetN = 1'b1;
    tick();
    check("t6.no_ng", 32'(newGamePulse), 32'd0);
    check("t6.no_ls", 32'(levelStartPulse), 32'd0);

    // Random event run
    for (int c = 0; c < 10000; c++) begin
      startOfFrame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) startKey = ~startKey;
      if ($urandom_range(0, 39) == 0) pauseKey = ~pauseKey;
      playerDied   = ($urandom_range(0, 79) == 0);
      levelCleared = ($urandom_range(0, 99) == 0);
      resetN       = ($urandom_range(0, 4999) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
